// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipe: runs loads/stores over a req/ack port,
// stalls upstream until ack, and loads the MEM/WB register.
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   WBreg, Mreg             WB/M controls from EX/MEM
//   ALUreg, WriteDataOut    address / pass-through value, store data
//   RegRDreg                destination register
//   mem_req/we/addr/wdata   data memory request (held until ack)
//   mem_rdata, mem_ack      load data, one-cycle completion strobe
//   stall                   hold upstream this cycle (combinational)
//   mem_err                 one-cycle pulse on access timeout
//   WBout, ReadDataOut,
//   ALUOutWB, RegRDout      MEM/WB register
//
// Option: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
// BUSY cycles without ack; otherwise BUSY waits forever, mem_err=0.

module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        WBreg,
    input  logic [2:0]        Mreg,
    input  logic [DATA_W-1:0] ALUreg,
    input  logic [DATA_W-1:0] WriteDataOut,
    input  logic [4:0]        RegRDreg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              mem_err,
    output logic [1:0]        WBout,
    output logic [DATA_W-1:0] ReadDataOut,
    output logic [DATA_W-1:0] ALUOutWB,
    output logic [4:0]        RegRDout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic       access;
    logic       abort;
    logic       unused_ok;

    // Both MemRead and MemWrite set falls out as a store via Mreg[0].
    assign access    = Mreg[1] | Mreg[0];
    // Branch is resolved elsewhere.
    assign unused_ok = ^{Mreg[2], TIMEOUT[0]};

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tcnt;

    assign abort = (state == BUSY) && !mem_ack && (tcnt == TO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= abort;
            if (state == IDLE)
                tcnt <= '0;
            else if (!mem_ack)
                tcnt <= tcnt + 8'd1;
        end
    end
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        if (state == IDLE)
            stall = access;
        else
            stall = !(mem_ack || abort);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            WBout       <= '0;
            ReadDataOut <= '0;
            ALUOutWB    <= '0;
            RegRDout    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        mem_req     <= 1'b1;
                        mem_we      <= Mreg[0];
                        mem_addr    <= ALUreg[ADDR_W-1:0];
                        mem_wdata   <= WriteDataOut;
                        state       <= BUSY;
                        WBout       <= '0;
                        ReadDataOut <= '0;
                        ALUOutWB    <= '0;
                        RegRDout    <= '0;
                    end else begin
                        WBout       <= WBreg;
                        ReadDataOut <= '0;
                        ALUOutWB    <= ALUreg;
                        RegRDout    <= RegRDreg;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        state       <= IDLE;
                        WBout       <= WBreg;
                        ReadDataOut <= mem_we ? '0 : mem_rdata;
                        ALUOutWB    <= ALUreg;
                        RegRDout    <= RegRDreg;
                    end else begin
                        if (abort) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                        WBout       <= '0;
                        ReadDataOut <= '0;
                        ALUOutWB    <= '0;
                        RegRDout    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
